// File: rtl/dmem_dump_reader_pkg.sv
// Shared types and defaults for the data-memory dump reader.
package dmem_dump_pkg;
  typedef enum logic [2:0] {IDLE, READ, CAPT, SEND, CSUM, FIN} state_e;

  localparam int ADDR_W_DEFAULT = 16;
  localparam int DATA_W_DEFAULT = 16;
  localparam logic [15:0] HALT_OP_DEFAULT = 16'hF000;
endpackage

// File: rtl/dmem_dump_reader_if.sv
// Memory read port plus (addr, data) output stream of the dump reader.
interface dmem_dump_reader_if import dmem_dump_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output rd_en, rd_addr, out_valid, out_addr, out_data, out_last,
    input  rd_data, out_ready
  );
  modport slave (
    input  rd_en, rd_addr, out_valid, out_addr, out_data, out_last,
    output rd_data, out_ready
  );
endinterface

// File: rtl/dmem_dump_reader.sv
// Dumps data memory BASE_ADDR..LAST_ADDR as a valid/ready stream after a halt.
// DUMP_CHECKSUM_EN appends a wrapping-sum beat at address LAST_ADDR+1.
module dmem_dump_reader import dmem_dump_pkg::*; #(
  parameter int                ADDR_W    = ADDR_W_DEFAULT,
  parameter int                DATA_W    = DATA_W_DEFAULT,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(255),
  parameter logic [15:0]       HALT_OP   = HALT_OP_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         mem_instr,
  dmem_dump_reader_if.master  bus,
  output logic                busy,
  output logic                done
);
  state_e            state;
  logic [ADDR_W-1:0] cnt;
  logic              at_last;

  // Counter only advances when not at LAST_ADDR, so it can never wrap.
  assign at_last = (cnt == LAST_ADDR);

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= BASE_ADDR;
      bus.rd_en     <= 1'b0;
      bus.rd_addr   <= '0;
      bus.out_valid <= 1'b0;
      bus.out_addr  <= '0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum           <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (mem_instr == HALT_OP && !done) begin
          state       <= READ;
          busy        <= 1'b1;
          bus.rd_en   <= 1'b1;
          bus.rd_addr <= cnt;
        end
        READ: begin
          bus.rd_en <= 1'b0;
          state     <= CAPT;
        end
        CAPT: begin
          bus.out_data  <= bus.rd_data;
          bus.out_addr  <= cnt;
          bus.out_valid <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
          bus.out_last  <= 1'b0;
`else
          bus.out_last  <= at_last;
`endif
          state         <= SEND;
        end
        SEND: if (bus.out_ready) begin
`ifdef DUMP_CHECKSUM_EN
          sum <= sum + bus.out_data;
`endif
          if (at_last) begin
`ifdef DUMP_CHECKSUM_EN
            // Valid stays high: the checksum beat follows back to back.
            bus.out_addr <= LAST_ADDR + 1'b1;
            bus.out_data <= sum + bus.out_data;
            bus.out_last <= 1'b1;
            state        <= CSUM;
`else
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
            state         <= FIN;
`endif
          end else begin
            bus.out_valid <= 1'b0;
            cnt           <= cnt + 1'b1;
            bus.rd_en     <= 1'b1;
            bus.rd_addr   <= cnt + 1'b1;
            state         <= READ;
          end
        end
        CSUM: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.out_last  <= 1'b0;
          busy          <= 1'b0;
          done          <= 1'b1;
          state         <= FIN;
        end
        FIN: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
